stream_demux1x2: RTL
====================

// Module: stream_demux1x2
// PURPOSE
//  1-to-2 stream demultiplexer: the distribution side of mux2x1.
//  Takes one valid/ready input stream and steers each beat to output 0 or 1 by in_sel.
//  Each output has a one-entry registered buffer, so data arrives one cycle after acceptance.
//  Sits between a single producer (e.g. ALU result stream) and two consumers.
// PARAMETERS
//  DATA_W  8   width of in_data / out0_data / out1_data
//  CNT_W   16  width of per-output transfer counters (used only with STREAM_DEMUX_CNT_EN)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous active-high reset
//  in_valid   in   1       input beat present
//  in_ready   out  1       input beat accepted this cycle when in_valid & in_ready
//  in_sel     in   1       destination: 0 -> out0, 1 -> out1
//  in_data    in   DATA_W  input payload
//  out0_valid out  1       out0 buffer holds a beat
//  out0_ready in   1       consumer 0 takes beat
//  out0_data  out  DATA_W  out0 payload (registered)
//  out1_valid out  1       as out0, for channel 1
//  out1_ready in   1
//  out1_data  out  DATA_W
//  out0_cnt   out  CNT_W   completed out0 transfers (only with STREAM_DEMUX_CNT_EN)
//  out1_cnt   out  CNT_W   completed out1 transfers (only with STREAM_DEMUX_CNT_EN)
// BEHAVIOUR
//  - Reset (async, rst=1): outN_valid=0, outN_data=0, outN_cnt=0. A buffered beat is dropped.
//    in_ready=0 while rst=1. Normal operation resumes on the first clk edge after rst falls.
//  - Per-channel state: EMPTY (valid=0) or FULL (valid=1).
//  - chN_free = !outN_valid | outN_ready. in_ready = in_sel ? ch1_free : ch0_free (combinational).
//  - accN = in_valid & in_ready & (in_sel==N). On accN: outN_data<=in_data, outN_valid<=1 (EMPTY/FULL->FULL).
//  - FULL, outN_ready=1, no accN -> EMPTY. FULL, outN_ready=0 -> hold data and valid.
//  - Latency 1 clk from accept to outN_valid. Throughput 1 beat/clk per channel with ready held high.
//  - Simultaneous drain and load on the same channel: the new beat replaces the old. No bubble, no loss.
//  - The unselected channel is unaffected by in_data/in_valid and drains independently.
//  - A stall on one channel never blocks beats addressed to the other channel.
//  - Protocol: the producer holds in_valid/in_sel/in_data stable until accepted. Bench asserts this.
//  - outN_valid never drops without an outN_ready handshake. outN_data is stable while FULL and stalled.
//  - in_valid=0: no state change except draining.
// CONFIGURATION
//  STREAM_DEMUX_CNT_EN defined: outN_cnt increments by 1 on each outN_valid & outN_ready.
//    Unsigned, wraps from 2^CNT_W-1 to 0. Reset to 0.
//  STREAM_DEMUX_CNT_EN undefined: no counter registers. outN_cnt ports are tied to 0.
// TESTING
//  1 rst=1 mid-stream with out0 FULL -> out0_valid=0 immediately (async), data=0, in_ready=0.
//  2 sel=0, data=8'hA5, out0_ready=1 -> next clk out0_valid=1, out0_data=A5; out1_valid stays 0.
//  3 out1_ready=0, send 8'h11 then 8'h22 to ch1 -> 8'h11 held, in_ready=0 for 8'h22.
//    Raise out1_ready -> 8'h11 handshakes and 8'h22 loads in the same clk.
//  4 out1 stalled FULL, sel=0 beat 8'h33 -> accepted, out0_data=33 next clk.
//  5 out0_ready=1 continuously, 4 back-to-back beats 01..04 to ch0 -> one per clk, in order, no gaps.
//  6 CNT_EN, CNT_W=4: 17 out1 transfers -> out1_cnt=1 (wrap). Without the macro, outN_cnt stays 0.

Source files
------------

// File: rtl/stream_demux1x2.sv
// stream_demux1x2: steers each input beat to out0/out1 by in_sel through a one-entry registered buffer (1 clk latency).
// in_ready follows only the selected channel, so a stalled channel never blocks the other; STREAM_DEMUX_CNT_EN adds transfer counters.
module stream_demux1x2 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sel,
  input  logic [DATA_W-1:0] in_data,
  output logic              out0_valid,
  input  logic              out0_ready,
  output logic [DATA_W-1:0] out0_data,
  output logic              out1_valid,
  input  logic              out1_ready,
  output logic [DATA_W-1:0] out1_data,
  output logic [CNT_W-1:0]  out0_cnt,
  output logic [CNT_W-1:0]  out1_cnt
);

  logic ch0_free;
  logic ch1_free;
  logic acc0;
  logic acc1;

  // A full buffer still counts as free when its consumer drains it this cycle.
  assign ch0_free = !out0_valid || out0_ready;
  assign ch1_free = !out1_valid || out1_ready;

  assign in_ready = !rst && (in_sel ? ch1_free : ch0_free);

  assign acc0 = in_valid && in_ready && !in_sel;
  assign acc1 = in_valid && in_ready &&  in_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0_valid <= 1'b0;
      out0_data  <= '0;
    end else if (acc0) begin
      out0_valid <= 1'b1;
      out0_data  <= in_data;
    end else if (out0_ready) begin
      out0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_valid <= 1'b0;
      out1_data  <= '0;
    end else if (acc1) begin
      out1_valid <= 1'b1;
      out1_data  <= in_data;
    end else if (out1_ready) begin
      out1_valid <= 1'b0;
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (out0_valid && out0_ready) cnt0_q <= cnt0_q + 1'b1;
      if (out1_valid && out1_ready) cnt1_q <= cnt1_q + 1'b1;
    end
  end

  assign out0_cnt = cnt0_q;
  assign out1_cnt = cnt1_q;
`else
  assign out0_cnt = '0;
  assign out1_cnt = '0;
`endif

endmodule
